// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared definitions for the main-memory arbiter and the two cache
//            controllers that sit above it.
// Revision : 1.0
// ============================================================================
package mem_pkg;

    // Default bus widths shared with the instruction and data cache controllers
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_LINE_W = 128;

    // Arbiter controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Transaction owner encoding
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin grant. Under contention the side opposite
//            the last-served side wins; the pointer moves when a transaction
//            retires.
// Revision : 1.0
// ============================================================================
module rr_arb2
    import mem_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic update_i,
    input  logic owner_i,
    output logic valid_o,
    output logic grant_o
);

    logic last_q;
    logic last_d;

    // Grant selection and pointer next-state
    always_comb begin
        valid_o = i_req_i | d_req_i;
        grant_o = OWNER_I;
        last_d  = last_q;
        if (i_req_i && d_req_i) begin
            grant_o = (last_q == OWNER_I) ? OWNER_D : OWNER_I;
        end else if (d_req_i) begin
            grant_o = OWNER_D;
        end
        if (update_i) begin
            last_d = owner_i;
        end
    end

    // Last-served pointer; starts at I so D wins the first contention
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= OWNER_I;
        end else begin
            last_q <= last_d;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates I-cache line fills and D-cache fills / write-backs
//            onto a single main-memory port. All outputs are registered.
// Revision : 1.0
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int LINE_W = MEM_LINE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata
);

    // Clears the byte-within-line offset so memory only ever sees aligned lines
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    state_t            state_q,     state_d;
    logic              owner_q,     owner_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ack_q,     i_ack_d;
    logic              d_ack_q,     d_ack_d;
    logic [LINE_W-1:0] i_rdata_q,   i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q,   d_rdata_d;

    logic w_arb_valid;
    logic w_arb_grant;
    logic w_arb_update;

    rr_arb2 u_rr_arb2 (
        .clock    (clock),
        .reset    (reset),
        .i_req_i  (i_req),
        .d_req_i  (d_req),
        .update_i (w_arb_update),
        .owner_i  (owner_q),
        .valid_o  (w_arb_valid),
        .grant_o  (w_arb_grant)
    );

    // Next-state and output-register logic for the IDLE/MEM/RESP controller
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        w_arb_update = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    owner_d   = w_arb_grant;
                    mem_req_d = 1'b1;
                    state_d   = ST_MEM;
                    if (w_arb_grant == OWNER_D) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr & LINE_MASK;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr & LINE_MASK;
                        mem_wdata_d = '0;
                    end
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                    if (owner_q == OWNER_D) begin
                        d_ack_d = 1'b1;
                        // Write-backs leave the last fill data visible
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_rdata;
                    end
                end
            end
            ST_RESP: begin
                w_arb_update = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_I;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a behavioural memory
//            responder and an expected-grant queue.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         i_req = 1'b0;
    logic [31:0]  i_addr = '0;
    logic         i_ack;
    logic [127:0] i_rdata;
    logic         d_req = 1'b0;
    logic         d_we = 1'b0;
    logic [31:0]  d_addr = '0;
    logic [127:0] d_wdata = '0;
    logic         d_ack;
    logic [127:0] d_rdata;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack = 1'b0;
    logic [127:0] mem_rdata = '0;

    mem_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         side;   // 0 = I, 1 = D
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        int           delay;  // MEM cycles before mem_ack
        logic [127:0] rdata;
    } vec_t;

    typedef struct {
        logic         side;
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] i_rdata_m = '0;
    logic [127:0] d_rdata_m = '0;
    vec_t         vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic exp_t make_exp(input vec_t v);
        exp_t e;
        e.side  = v.side;
        e.we    = v.side ? v.we : 1'b0;
        e.addr  = v.addr & 32'hFFFF_FFF0;
        e.wdata = v.wdata;
        return e;
    endfunction

    task automatic drive_req(input vec_t v);
        if (v.side) begin
            d_req   = 1'b1;
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end else begin
            i_req  = 1'b1;
            i_addr = v.addr;
        end
    endtask

    task automatic wait_mem_req(output int lat);
        lat = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clock);
            if (mem_req === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check("mem_req_timeout", 128'(mem_req), 128'd1);
    endtask

    task automatic check_grant(output exp_t e);
        e = '{side: 1'b0, we: 1'b0, addr: '0, wdata: '0};
        if (sb.size() == 0) begin
            check("scoreboard_empty", 128'd0, 128'd1);
            return;
        end
        e = sb.pop_front();
        check("grant_mem_we", 128'(mem_we), 128'(e.we));
        check("grant_mem_addr", 128'(mem_addr), 128'(e.addr));
        if (e.side && e.we) check("grant_mem_wdata", mem_wdata, e.wdata);
    endtask

    // Memory responder: hold off for delay cycles, then pulse mem_ack
    task automatic serve(input exp_t e, input int delay, input logic [127:0] rdata, input bit drop);
        for (int k = 0; k < delay; k++) begin
            check("hold_mem_req", 128'(mem_req), 128'd1);
            check("hold_mem_addr", 128'(mem_addr), 128'(e.addr));
            check("no_early_ack", 128'({i_ack, d_ack}), 128'd0);
            mem_rdata = rnd128();
            @(negedge clock);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clock);
        mem_ack   = 1'b0;
        mem_rdata = rnd128();
        if (e.side == 1'b0) i_rdata_m = rdata;
        else if (!e.we)     d_rdata_m = rdata;
        check("resp_i_ack", 128'(i_ack), 128'(!e.side));
        check("resp_d_ack", 128'(d_ack), 128'(e.side));
        check("resp_i_rdata", i_rdata, i_rdata_m);
        check("resp_d_rdata", d_rdata, d_rdata_m);
        check("resp_mem_req", 128'(mem_req), 128'd0);
        if (drop) begin
            i_req = 1'b0;
            d_req = 1'b0;
        end
        @(negedge clock);
        check("ack_single_pulse", 128'({i_ack, d_ack}), 128'd0);
    endtask

    task automatic run_txn(input vec_t v);
        exp_t e;
        int   lat;
        sb.push_back(make_exp(v));
        drive_req(v);
        wait_mem_req(lat);
        check("req_latency", 128'(lat), 128'd1);
        check_grant(e);
        serve(e, v.delay, v.rdata, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},   128'(mem_req),   128'd0);
        check({tag, "_mem_we"},    128'(mem_we),    128'd0);
        check({tag, "_mem_addr"},  128'(mem_addr),  128'd0);
        check({tag, "_mem_wdata"}, mem_wdata,       128'd0);
        check({tag, "_acks"},      128'({i_ack, d_ack}), 128'd0);
        check({tag, "_i_rdata"},   i_rdata,         128'd0);
        check({tag, "_d_rdata"},   d_rdata,         128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vi, vd, vr;
        exp_t e;
        int   lat;

        vecs[0] = '{side: 1'b0, we: 1'b0, addr: 32'h0000_0040, wdata: '0,                                     delay: 3,  rdata: {16{8'hA5}}};
        vecs[1] = '{side: 1'b1, we: 1'b1, addr: 32'h0000_0100, wdata: 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0, delay: 1,  rdata: 128'hDEAD_BEEF};
        vecs[2] = '{side: 1'b1, we: 1'b0, addr: 32'h0000_0108, wdata: 128'h5555,                               delay: 0,  rdata: 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555};
        vecs[3] = '{side: 1'b0, we: 1'b0, addr: 32'hFFFF_FFF7, wdata: '0,                                     delay: 2,  rdata: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        vecs[4] = '{side: 1'b1, we: 1'b1, addr: 32'h8000_0020, wdata: 128'hFACE_B00C_0000_0000_AAAA_BBBB_CCCC_DDDD, delay: 20, rdata: 128'h7777};
        vecs[5] = '{side: 1'b0, we: 1'b0, addr: 32'h0000_0000, wdata: '0,                                     delay: 0,  rdata: {128{1'b1}}};

        // Reset state
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clock);

        // Sustained contention straight after reset: D, I, D, I
        vi = '{side: 1'b0, we: 1'b0, addr: 32'h0000_0200, wdata: '0, delay: 0, rdata: '0};
        vd = '{side: 1'b1, we: 1'b0, addr: 32'h0000_0300, wdata: '0, delay: 0, rdata: '0};
        sb.push_back(make_exp(vd));
        sb.push_back(make_exp(vi));
        sb.push_back(make_exp(vd));
        sb.push_back(make_exp(vi));
        drive_req(vi);
        drive_req(vd);
        for (int t = 0; t < 4; t++) begin
            wait_mem_req(lat);
            check_grant(e);
            serve(e, 0, 128'h1000 + 128'(t), t == 3);
        end

        // Table of single-requester transactions
        for (int n = 0; n < 6; n++) begin
            run_txn(vecs[n]);
            check("d_ack_idle_after_txn", 128'(vecs[n].side ? 1'b0 : d_ack), 128'd0);
        end

        // Spurious mem_ack while idle
        mem_ack   = 1'b1;
        mem_rdata = rnd128();
        @(negedge clock);
        mem_ack = 1'b0;
        check("spurious_acks", 128'({i_ack, d_ack}), 128'd0);
        check("spurious_mem_req", 128'(mem_req), 128'd0);
        check("spurious_i_rdata", i_rdata, i_rdata_m);
        check("spurious_d_rdata", d_rdata, d_rdata_m);
        @(negedge clock);
        check("spurious_acks_late", 128'({i_ack, d_ack}), 128'd0);
        vr = '{side: 1'b1, we: 1'b0, addr: 32'h0000_0440, wdata: '0, delay: 1, rdata: 128'hBEEF_0001};
        run_txn(vr);

        // Reset asserted mid-MEM abandons the transaction
        vr = '{side: 1'b0, we: 1'b0, addr: 32'h0000_0500, wdata: '0, delay: 0, rdata: '0};
        sb.push_back(make_exp(vr));
        drive_req(vr);
        wait_mem_req(lat);
        check_grant(e);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_all_zero("midmem_reset");
        i_req     = 1'b0;
        i_rdata_m = '0;
        d_rdata_m = '0;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("no_stale_ack", 128'({i_ack, d_ack}), 128'd0);
        end
        vr = '{side: 1'b0, we: 1'b0, addr: 32'h0000_0600, wdata: '0, delay: 1, rdata: 128'h600D_0600};
        run_txn(vr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
